uart_tx_frame_ctrl: RTL and testbench

Parametrised UART transmit controller: the next generation of the UART_TX control FSM. It integrates the frame FSM, serializer, parity generator and bit-period timer. Runtime options: data width, parity enable/type, 1 or 2 stop bits, and a runtime baud prescale. It sits between the byte source (valid/busy handshake) and the TX pad, and drives the serial line directly.

---
 rtl/uart_tx_pkg.sv | 22 ++
 rtl/uart_tx_bit_timer.sv | 40 ++++
 rtl/uart_tx_frame_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_uart_tx_frame_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_pkg
// Brief    : Shared state codes and line-level constants for the UART TX block
// Revision : 1.0
// ============================================================================
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_START  = 3'b001,
    ST_DATA   = 3'b011,
    ST_PARITY = 3'b010,
    ST_STOP   = 3'b110
  } state_e;

  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_tx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_bit_timer
// Brief    : Bit-period down-counter; expire_o is high in the last cycle of a bit
// Revision : 1.0
// ============================================================================
module uart_tx_bit_timer #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load_i,
  input  logic [PRESCALE_W-1:0] load_val_i,
  output logic                  expire_o
);

  logic [PRESCALE_W-1:0] cnt_q;
  logic [PRESCALE_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - PRESCALE_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/uart_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame_ctrl
// Brief    : UART transmit frame FSM, serializer and parity with runtime options
// Revision : 1.0
// ============================================================================
module uart_tx_frame_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  stop2,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int                IDX_W      = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0]  c_LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  stop_q, stop_d;
  logic                  par_bit_q, par_bit_d;
  logic                  par_en_q, par_en_d;
  logic                  stop2_q, stop2_d;
  logic [PRESCALE_W-1:0] ps_m1_q, ps_m1_d;

  logic                  w_tmr_load;
  logic [PRESCALE_W-1:0] w_tmr_val;
  logic                  w_expire;
  logic [PRESCALE_W-1:0] w_ps_m1_in;

  assign w_ps_m1_in = (prescale == '0) ? '0 : prescale - PRESCALE_W'(1);

  uart_tx_bit_timer #(
    .PRESCALE_W (PRESCALE_W)
  ) u_timer (
    .CLK        (CLK),
    .RST        (RST),
    .load_i     (w_tmr_load),
    .load_val_i (w_tmr_val),
    .expire_o   (w_expire)
  );

  // Outputs are computed for the state being entered so they can be registered.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sh_d       = sh_q;
    idx_d      = idx_q;
    stop_d     = stop_q;
    par_bit_d  = par_bit_q;
    par_en_d   = par_en_q;
    stop2_d    = stop2_q;
    ps_m1_d    = ps_m1_q;
    w_tmr_load = 1'b0;
    w_tmr_val  = ps_m1_q;

    case (state_q)
      ST_IDLE: begin
        tx_d   = IDLE_LEVEL;
        busy_d = 1'b0;
        if (data_valid) begin
          sh_d       = p_data;
          par_bit_d  = (^p_data) ^ (par_typ == PAR_ODD);
          par_en_d   = par_en;
          stop2_d    = stop2;
          ps_m1_d    = w_ps_m1_in;
          w_tmr_load = 1'b1;
          w_tmr_val  = w_ps_m1_in;
          state_d    = ST_START;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end

      ST_START: begin
        if (w_expire) begin
          w_tmr_load = 1'b1;
          state_d    = ST_DATA;
          idx_d      = '0;
          tx_d       = sh_q[0];
          sh_d       = sh_q >> 1;
        end
      end

      ST_DATA: begin
        if (w_expire) begin
          w_tmr_load = 1'b1;
          if (idx_q == c_LAST_IDX) begin
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = IDLE_LEVEL;
              stop_d  = 1'b0;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
            tx_d  = sh_q[0];
            sh_d  = sh_q >> 1;
          end
        end
      end

      ST_PARITY: begin
        if (w_expire) begin
          w_tmr_load = 1'b1;
          state_d    = ST_STOP;
          tx_d       = IDLE_LEVEL;
          stop_d     = 1'b0;
        end
      end

      ST_STOP: begin
        if (w_expire) begin
          if (stop2_q && !stop_q) begin
            w_tmr_load = 1'b1;
            stop_d     = 1'b1;
          end else begin
            state_d = ST_IDLE;
            tx_d    = IDLE_LEVEL;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = IDLE_LEVEL;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      tx_q      <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sh_q      <= '0;
      idx_q     <= '0;
      stop_q    <= 1'b0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      ps_m1_q   <= '0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sh_q      <= sh_d;
      idx_q     <= idx_d;
      stop_q    <= stop_d;
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
      stop2_q   <= stop2_d;
      ps_m1_q   <= ps_m1_d;
    end
  end

  assign tx_out  = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_frame_ctrl
// Brief    : Scoreboard bench: frames queued at issue, monitor compares whole lines
// Revision : 1.0
// ============================================================================
module tb_uart_tx_frame_ctrl;

  localparam int DW    = 8;
  localparam int PW    = 8;
  localparam int LIMIT = 4000;

  typedef struct {
    logic [DW-1:0] data;
    logic          pen;
    logic          ptyp;
    logic          s2;
    int            ps;
  } frame_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_en;
  logic          par_typ;
  logic          stop2;
  logic [PW-1:0] prescale;
  logic          tx_out;
  logic          busy;
  logic          tx_done;

  int     errors = 0;
  int     checks = 0;
  frame_t exp_q[$];
  logic   wave[$];
  frame_t mon_f;

  uart_tx_frame_ctrl #(
    .DATA_WIDTH (DW),
    .PRESCALE_W (PW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .stop2      (stop2),
    .prescale   (prescale),
    .tx_out     (tx_out),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: frame as an ordered list of slots, each held for ps cycles.
  function automatic int eff_ps(input frame_t f);
    return (f.ps == 0) ? 1 : f.ps;
  endfunction

  function automatic int exp_len(input frame_t f);
    return (1 + DW + int'(f.pen) + 1 + int'(f.s2)) * eff_ps(f);
  endfunction

  function automatic logic exp_bit(input frame_t f, input int cyc);
    int   slot;
    logic par;
    slot = cyc / eff_ps(f);
    par  = logic'(($countones(f.data) % 2) == 1) ^ f.ptyp;
    if (slot == 0)                   return 1'b0;
    if (slot <= DW)                  return f.data[slot-1];
    if (f.pen && slot == DW + 1)     return par;
    return 1'b1;
  endfunction

  // Monitor: gather tx_out over each busy period, compare when tx_done appears.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST !== 1'b1) begin
        wave.delete();
        continue;
      end
      if (busy) wave.push_back(tx_out);
      if (tx_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          int mism;
          int first;
          mon_f = exp_q.pop_front();
          mism  = 0;
          first = -1;
          chk("frame_len", wave.size(), exp_len(mon_f));
          foreach (wave[i]) begin
            if (i < exp_len(mon_f) && wave[i] !== exp_bit(mon_f, i)) begin
              mism++;
              if (first < 0) first = i;
            end
          end
          if (mism != 0)
            $display("  data=%h pen=%0b ptyp=%0b s2=%0b ps=%0d first bad cycle %0d",
                     mon_f.data, mon_f.pen, mon_f.ptyp, mon_f.s2, mon_f.ps, first);
          chk("frame_wave_mismatches", mism, 0);
          chk("done_line_idle", int'(tx_out), 1);
        end
        wave.delete();
      end
    end
  end

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < LIMIT && !seen; i++) begin
      @(negedge CLK);
      if (tx_done) seen = 1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  // Present a frame; the DUT is idle so it is accepted on the next edge.
  task automatic send(input frame_t f, input bit keep_valid, input int junk);
    p_data     = f.data;
    par_en     = f.pen;
    par_typ    = f.ptyp;
    stop2      = f.s2;
    prescale   = PW'(f.ps);
    data_valid = 1'b1;
    exp_q.push_back(f);
    @(posedge CLK); #1;
    if (!keep_valid) begin
      repeat (junk) begin
        p_data   = DW'($urandom);
        par_en   = 1'($urandom);
        par_typ  = 1'($urandom);
        stop2    = 1'($urandom);
        prescale = PW'($urandom);
        @(posedge CLK); #1;
      end
      data_valid = 1'b0;
      p_data     = DW'($urandom);
      prescale   = PW'($urandom);
    end
  endtask

  function automatic frame_t mk(input logic [DW-1:0] d, input logic pen, input logic pt,
                                input logic s2, input int ps);
    frame_t f;
    f.data = d; f.pen = pen; f.ptyp = pt; f.s2 = s2; f.ps = ps;
    return f;
  endfunction

  initial begin
    frame_t f;
    int     bad;
    RST = 1'b0; data_valid = 1'b0; p_data = '0; par_en = 1'b0;
    par_typ = 1'b0; stop2 = 1'b0; prescale = '0;
    repeat (2) @(negedge CLK);
    chk("reset_tx_out", int'(tx_out), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(tx_done), 0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    send(mk(8'hA5, 1, 0, 0, 4), 0, 0); wait_done();
    send(mk(8'hA5, 1, 1, 0, 4), 0, 0); wait_done();
    send(mk(8'h3C, 0, 0, 1, 2), 0, 0); wait_done();
    send(mk(8'hFF, 0, 0, 0, 0), 0, 0); wait_done();
    @(negedge CLK);

    // Held data_valid: mid-frame input changes only affect the next frame.
    send(mk(8'hA5, 1, 0, 0, 3), 1, 0);
    repeat (5) begin @(posedge CLK); #1; end
    p_data = 8'h00; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b1; prescale = 8'd2;
    exp_q.push_back(mk(8'h00, 0, 0, 1, 2));
    wait_done();
    @(posedge CLK); #1;
    data_valid = 1'b0;
    wait_done();
    repeat (2) @(negedge CLK);

    // Reset in the middle of data bit 3.
    send(mk(8'h5A, 1, 0, 0, 3), 0, 0);
    repeat (13) @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    chk("midreset_tx_out", int'(tx_out), 1);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_done", int'(tx_done), 0);
    exp_q.delete();
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    bad = 0;
    repeat (12) begin
      @(negedge CLK);
      if (busy || tx_done || !tx_out) bad++;
    end
    chk("post_reset_idle", bad, 0);

    for (int n = 0; n < 20; n++) begin
      f = mk(DW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 6)));
      send(f, 0, int'($urandom_range(0, 3)));
      wait_done();
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end

    repeat (4) @(negedge CLK);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
